// File: rtl/rggen_bus_slice.sv
// rggen_bus_slice: one-deep register slice between an rggen-style upstream
// bus master and a downstream register block. A request is captured in IDLE,
// presented downstream in REQUEST until accepted, and the response is
// returned upstream as a one-cycle o_s_ready pulse in RESPONSE. Every output
// comes from a flop, so there is no combinational path from input to output.
//
// Optional feature (macro RGGEN_BUS_SLICE_TIMEOUT_EN): a downstream timeout.
// A request that is not accepted within TIMEOUT cycles is answered upstream
// with RGGEN_SLAVE_ERROR and zero read data. Without the macro, REQUEST waits
// for i_m_ready indefinitely.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_s_valid/address/write/write_data/strobe   upstream request
//   o_s_ready/status/read_data                  upstream response
//   o_m_valid/address/write/write_data/strobe   downstream request
//   i_m_ready/status/read_data                  downstream response
// Status encoding: 00 OKAY, 01 EXOKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR.

module rggen_bus_slice #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned BUS_WIDTH     = 32,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_s_valid,
  input  logic [ADDRESS_WIDTH-1:0] i_s_address,
  input  logic                     i_s_write,
  input  logic [BUS_WIDTH-1:0]     i_s_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_s_strobe,
  output logic                     o_s_ready,
  output logic [1:0]               o_s_status,
  output logic [BUS_WIDTH-1:0]     o_s_read_data,
  output logic                     o_m_valid,
  output logic [ADDRESS_WIDTH-1:0] o_m_address,
  output logic                     o_m_write,
  output logic [BUS_WIDTH-1:0]     o_m_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_m_strobe,
  input  logic                     i_m_ready,
  input  logic [1:0]               i_m_status,
  input  logic [BUS_WIDTH-1:0]     i_m_read_data
);

  localparam int unsigned STROBE_WIDTH = BUS_WIDTH / 8;

  localparam logic [1:0] RGGEN_OKAY        = 2'b00;
  localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    RESPONSE = 2'd2
  } state_e;

  state_e                   r_state;
  logic                     r_m_valid;
  logic [ADDRESS_WIDTH-1:0] r_m_address;
  logic                     r_m_write;
  logic [BUS_WIDTH-1:0]     r_m_write_data;
  logic [STROBE_WIDTH-1:0]  r_m_strobe;
  logic                     r_s_ready;
  logic [1:0]               r_s_status;
  logic [BUS_WIDTH-1:0]     r_s_read_data;

`ifdef RGGEN_BUS_SLICE_TIMEOUT_EN
  localparam int unsigned            COUNT_WIDTH  = 16;
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT - 1);

  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_timeout;

  // Abort only when the downstream has not answered in the last allowed cycle;
  // a ready in that same cycle wins.
  assign w_timeout = (r_count == TIMEOUT_LAST) && !i_m_ready;
`else
  // TIMEOUT only matters when the timeout is built in.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  // Slice FSM with all outputs registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_m_valid      <= 1'b0;
      r_m_address    <= '0;
      r_m_write      <= 1'b0;
      r_m_write_data <= '0;
      r_m_strobe     <= '0;
      r_s_ready      <= 1'b0;
      r_s_status     <= RGGEN_OKAY;
      r_s_read_data  <= '0;
`ifdef RGGEN_BUS_SLICE_TIMEOUT_EN
      r_count        <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_s_valid) begin
            r_m_valid      <= 1'b1;
            r_m_address    <= i_s_address;
            r_m_write      <= i_s_write;
            r_m_write_data <= i_s_write_data;
            r_m_strobe     <= i_s_strobe;
            r_state        <= REQUEST;
`ifdef RGGEN_BUS_SLICE_TIMEOUT_EN
            r_count        <= '0;
`endif
          end
        end
        REQUEST: begin
          if (i_m_ready) begin
            r_m_valid     <= 1'b0;
            r_s_ready     <= 1'b1;
            r_s_status    <= i_m_status;
            r_s_read_data <= i_m_read_data;
            r_state       <= RESPONSE;
          end
`ifdef RGGEN_BUS_SLICE_TIMEOUT_EN
          else if (w_timeout) begin
            r_m_valid     <= 1'b0;
            r_s_ready     <= 1'b1;
            r_s_status    <= RGGEN_SLAVE_ERROR;
            r_s_read_data <= '0;
            r_state       <= RESPONSE;
          end else begin
            r_count <= r_count + COUNT_WIDTH'(1);
          end
`endif
        end
        RESPONSE: begin
          r_s_ready <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_m_valid <= 1'b0;
          r_s_ready <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign o_m_valid      = r_m_valid;
  assign o_m_address    = r_m_address;
  assign o_m_write      = r_m_write;
  assign o_m_write_data = r_m_write_data;
  assign o_m_strobe     = r_m_strobe;
  assign o_s_ready      = r_s_ready;
  assign o_s_status     = r_s_status;
  assign o_s_read_data  = r_s_read_data;

endmodule

// File: tb/tb_rggen_bus_slice.sv
// Scoreboard bench for rggen_bus_slice: a downstream responder follows a
// per-request plan and checks the forwarded fields, a response monitor pops
// expected upstream responses and checks data, status and latency.
module tb_rggen_bus_slice;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_s_valid;
  logic [15:0] i_s_address;
  logic        i_s_write;
  logic [31:0] i_s_write_data;
  logic [3:0]  i_s_strobe;
  logic        o_s_ready;
  logic [1:0]  o_s_status;
  logic [31:0] o_s_read_data;
  logic        o_m_valid;
  logic [15:0] o_m_address;
  logic        o_m_write;
  logic [31:0] o_m_write_data;
  logic [3:0]  o_m_strobe;
  logic        i_m_ready;
  logic [1:0]  i_m_status;
  logic [31:0] i_m_read_data;

  typedef struct {
    int          wait_c;   // REQUEST cycle index that sees ready, -1 = never
    int          exp_len;  // expected o_m_valid cycles, -1 = unchecked
    logic [15:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  st;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] data;
  } resp_t;

  plan_t plan_q[$];
  resp_t exp_q[$];
  int    n_total = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    last_mv_cyc = -10;
  bit    idle_ready = 1'b0;

  rggen_bus_slice #(
    .ADDRESS_WIDTH(16),
    .BUS_WIDTH(32),
    .TIMEOUT(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_s_valid(i_s_valid),
    .i_s_address(i_s_address),
    .i_s_write(i_s_write),
    .i_s_write_data(i_s_write_data),
    .i_s_strobe(i_s_strobe),
    .o_s_ready(o_s_ready),
    .o_s_status(o_s_status),
    .o_s_read_data(o_s_read_data),
    .o_m_valid(o_m_valid),
    .o_m_address(o_m_address),
    .o_m_write(o_m_write),
    .o_m_write_data(o_m_write_data),
    .o_m_strobe(o_m_strobe),
    .i_m_ready(i_m_ready),
    .i_m_status(i_m_status),
    .i_m_read_data(i_m_read_data)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endfunction

  function automatic void fail_now(input string name, input string what);
    n_total++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endfunction

  // Downstream responder: pops a plan per request phase, checks held fields.
  initial begin : responder
    int    mc;
    bit    have;
    plan_t p;
    mc = 0;
    have = 1'b0;
    i_m_ready = 1'b0;
    i_m_status = DECERR;
    i_m_read_data = 32'hDEAD_0000;
    forever begin
      @(negedge clk);
      if (o_m_valid) begin
        if (mc == 0) begin
          if (plan_q.size() == 0) begin
            fail_now("unexpected_m_valid", "request with no plan");
            have = 1'b0;
          end else begin
            p = plan_q.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          chk("m_address", 64'(o_m_address), 64'(p.addr));
          chk("m_write", 64'(o_m_write), 64'(p.write));
          chk("m_write_data", 64'(o_m_write_data), 64'(p.wdata));
          chk("m_strobe", 64'(o_m_strobe), 64'(p.strb));
          i_m_ready = (mc == p.wait_c);
          i_m_status = p.st;
          i_m_read_data = p.rdata;
        end else begin
          i_m_ready = 1'b0;
        end
        last_mv_cyc = cyc;
        mc++;
      end else begin
        if (mc > 0 && have && p.exp_len >= 0)
          chk("m_valid_length", 64'(mc), 64'(p.exp_len));
        mc = 0;
        have = 1'b0;
        i_m_ready = idle_ready;
        i_m_status = DECERR;
        i_m_read_data = 32'hDEAD_0000;
      end
    end
  end

  // Upstream response monitor.
  initial begin : resp_mon
    bit    prev;
    resp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_s_ready) begin
        chk("s_ready_single_cycle", 64'(prev), 64'(0));
        if (exp_q.size() == 0) begin
          fail_now("unexpected_s_ready", "response pulse with nothing expected");
        end else begin
          e = exp_q.pop_front();
          chk("s_status", 64'(o_s_status), 64'(e.st));
          chk("s_read_data", 64'(o_s_read_data), 64'(e.data));
          chk("s_ready_latency", 64'(cyc), 64'(last_mv_cyc + 1));
        end
      end
      prev = o_s_ready;
    end
  end

  task automatic add_plan(input int w, input int len, input logic [15:0] a, input logic wr,
                          input logic [31:0] wd, input logic [3:0] s, input logic [1:0] st,
                          input logic [31:0] rd);
    plan_t p;
    p.wait_c = w; p.exp_len = len; p.addr = a; p.write = wr;
    p.wdata = wd; p.strb = s; p.st = st; p.rdata = rd;
    plan_q.push_back(p);
  endtask

  task automatic add_exp(input logic [1:0] st, input logic [31:0] d);
    resp_t e;
    e.st = st; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_req(input logic [15:0] a, input logic wr, input logic [31:0] wd,
                           input logic [3:0] s);
    i_s_valid = 1'b1; i_s_address = a; i_s_write = wr;
    i_s_write_data = wd; i_s_strobe = s;
  endtask

  // Drop valid and put junk on the fields; the slice must ignore it.
  task automatic scramble();
    i_s_valid = 1'b0; i_s_address = 16'hEEEE; i_s_write = 1'b1;
    i_s_write_data = 32'h5A5A_5A5A; i_s_strobe = 4'h9;
  endtask

  task automatic wait_mv(input logic lvl);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (o_m_valid === lvl) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("wait_m_valid", $sformatf("o_m_valid never reached %0b", lvl));
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && plan_q.size() == 0 && !o_m_valid && !o_s_ready) begin
        ok = 1'b1; break;
      end
    end
    if (!ok) fail_now("drain", $sformatf("%0d responses still outstanding", exp_q.size()));
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin : main
    int bad;
    rst = 1'b0;
    scramble();
    #1 rst = 1'b1;
    #1;
    chk("rst_m_valid", 64'(o_m_valid), 64'(0));
    chk("rst_m_address", 64'(o_m_address), 64'(0));
    chk("rst_m_write", 64'(o_m_write), 64'(0));
    chk("rst_m_write_data", 64'(o_m_write_data), 64'(0));
    chk("rst_m_strobe", 64'(o_m_strobe), 64'(0));
    chk("rst_s_ready", 64'(o_s_ready), 64'(0));
    chk("rst_s_status", 64'(o_s_status), 64'(OKAY));
    chk("rst_s_read_data", 64'(o_s_read_data), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Write accepted in the first REQUEST cycle.
    add_plan(0, 1, 16'h0010, 1'b1, 32'hDEAD_BEEF, 4'hF, OKAY, 32'hA5A5_A5A5);
    add_exp(OKAY, 32'hA5A5_A5A5);
    drive_req(16'h0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
    wait_mv(1'b1);
    scramble();
    drain();

    // Read with five wait cycles, SLAVE_ERROR response.
    add_plan(5, 6, 16'h0020, 1'b0, 32'h0000_0000, 4'h0, SLVERR, 32'h1234_5678);
    add_exp(SLVERR, 32'h1234_5678);
    drive_req(16'h0020, 1'b0, 32'h0000_0000, 4'h0);
    wait_mv(1'b1);
    scramble();
    drain();

    // Back-to-back reads with i_s_valid held high across both.
    add_plan(0, 1, 16'h0030, 1'b0, 32'h0, 4'h0, OKAY, 32'h1111_1111);
    add_plan(1, 2, 16'h0034, 1'b0, 32'h0, 4'h0, EXOKAY, 32'h2222_2222);
    add_exp(OKAY, 32'h1111_1111);
    add_exp(EXOKAY, 32'h2222_2222);
    drive_req(16'h0030, 1'b0, 32'h0, 4'h0);
    wait_mv(1'b1);
    i_s_address = 16'h0034;
    wait_mv(1'b0);
    wait_mv(1'b1);
    scramble();
    drain();

    // Downstream ready while idle is ignored; response fields hold.
    idle_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("idle_ready_m_valid", 64'(o_m_valid), 64'(0));
    end
    idle_ready = 1'b0;
    chk("held_s_status", 64'(o_s_status), 64'(EXOKAY));
    chk("held_s_read_data", 64'(o_s_read_data), 64'(32'h2222_2222));

    // Asynchronous reset during REQUEST abandons the transaction.
    add_plan(-1, -1, 16'h0040, 1'b1, 32'hCAFE_F00D, 4'h3, OKAY, 32'h0);
    drive_req(16'h0040, 1'b1, 32'hCAFE_F00D, 4'h3);
    wait_mv(1'b1);
    scramble();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_rst_m_valid", 64'(o_m_valid), 64'(0));
    chk("async_rst_s_ready", 64'(o_s_ready), 64'(0));
    chk("async_rst_s_status", 64'(o_s_status), 64'(OKAY));
    chk("async_rst_s_read_data", 64'(o_s_read_data), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    add_plan(2, 3, 16'h0050, 1'b0, 32'h0, 4'h0, OKAY, 32'h0BAD_C0DE);
    add_exp(OKAY, 32'h0BAD_C0DE);
    drive_req(16'h0050, 1'b0, 32'h0, 4'h0);
    wait_mv(1'b1);
    scramble();
    drain();

`ifdef RGGEN_BUS_SLICE_TIMEOUT_EN
    // Timeout after 4 REQUEST cycles; responder's status/data must be dropped.
    add_plan(-1, 4, 16'h0060, 1'b0, 32'h0, 4'h0, DECERR, 32'hFFFF_FFFF);
    add_exp(SLVERR, 32'h0000_0000);
    drive_req(16'h0060, 1'b0, 32'h0, 4'h0);
    wait_mv(1'b1);
    scramble();
    drain();
    // Ready in the last allowed cycle wins over the timeout.
    add_plan(3, 4, 16'h0064, 1'b0, 32'h0, 4'h0, OKAY, 32'h600D_F00D);
    add_exp(OKAY, 32'h600D_F00D);
    drive_req(16'h0064, 1'b0, 32'h0, 4'h0);
    wait_mv(1'b1);
    scramble();
    drain();
`else
    // Silent downstream: request stays up, no response.
    add_plan(-1, -1, 16'h0070, 1'b0, 32'h0, 4'h0, OKAY, 32'h0);
    drive_req(16'h0070, 1'b0, 32'h0, 4'h0);
    wait_mv(1'b1);
    scramble();
    bad = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (!o_m_valid || o_s_ready) bad++;
    end
    chk("silent_1000_bad_cycles", 64'(bad), 64'(0));
    reset_pulse();
`endif

    drain();
    chk("final_exp_q_empty", 64'(exp_q.size()), 64'(0));
    chk("final_plan_q_empty", 64'(plan_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
